rv32v_lane_sequencer: RTL and testbench

//  Sequences one vector arithmetic instruction across the NUM_LANES element lanes.

---
 rtl/rv32v_lane_sequencer.sv | 159 +++++++++++++++
 tb/tb_rv32v_lane_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rv32v_lane_sequencer.sv
// Walks element indices of one vector instruction, NUM_LANES per beat, with valid/ready handshake.
// Optional build macro RV32V_VSTART_EN: honour the vstart port (first index and lane masking).
module rv32v_lane_sequencer #(
  parameter int VLEN      = 128,
  parameter int NUM_LANES = 2,
  parameter int VL_W      = 8
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        start,
  input  logic [VL_W-1:0]             vl,
  input  logic [2:0]                  sew,
  input  logic [VL_W-1:0]             vstart,
  input  logic                        flush,
  output logic                        busy,
  output logic                        illegal,
  output logic                        beat_valid,
  input  logic                        beat_ready,
  output logic [VL_W-1:0]             elem_idx,
  output logic [NUM_LANES-1:0]        lane_en,
  output logic [2:0]                  reg_off,
  output logic [$clog2(VLEN/8)-1:0]   byte_off,
  output logic                        beat_last,
  output logic                        done
);

  localparam int VLENB = VLEN / 8;
  localparam int BO_W  = $clog2(VLENB);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [VL_W-1:0]   r_vl;
  logic [2:0]        r_sew;
`ifdef RV32V_VSTART_EN
  logic [VL_W-1:0]   r_vstart;
`endif

  logic [VL_W-1:0]      w_first;
  logic                 w_go_run;
  logic [VL_W-1:0]      w_src_idx;
  logic [VL_W-1:0]      w_src_vl;
  logic [2:0]           w_src_sew;
  logic [VL_W-1:0]      w_src_vst;
  logic [VL_W:0]        w_ext;
  logic [NUM_LANES-1:0] w_lane_en;
  logic                 w_beat_last;
  logic [2:0]           w_reg_off;
  logic [BO_W-1:0]      w_byte_off;

  // Beat fields are computed for the next beat: from the issue inputs in IDLE, else from the latched context.
  always_comb begin
    w_first     = '0;
    w_go_run    = 1'b0;
    w_src_vst   = '0;
`ifdef RV32V_VSTART_EN
    w_first   = vstart & ~VL_W'(NUM_LANES - 1);
    w_go_run  = (vstart < vl);
    w_src_vst = (r_state == S_IDLE) ? vstart : r_vstart;
`else
    w_src_vst = vstart & '0;
    w_go_run  = (vl != '0);
`endif
    w_src_idx   = (r_state == S_IDLE) ? w_first : elem_idx + VL_W'(NUM_LANES);
    w_src_vl    = (r_state == S_IDLE) ? vl  : r_vl;
    w_src_sew   = (r_state == S_IDLE) ? sew : r_sew;
    w_ext       = {1'b0, w_src_idx};
    w_lane_en   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_lane_en[i] = ((w_ext + (VL_W+1)'(i)) <  {1'b0, w_src_vl}) &&
                     ((w_ext + (VL_W+1)'(i)) >= {1'b0, w_src_vst});
    end
    w_beat_last = ((w_ext + (VL_W+1)'(NUM_LANES)) >= {1'b0, w_src_vl});
    w_reg_off   = 3'(w_src_idx >> (BO_W - int'(w_src_sew)));
    w_byte_off  = BO_W'(w_src_idx << w_src_sew);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= S_IDLE;
      r_vl       <= '0;
      r_sew      <= '0;
`ifdef RV32V_VSTART_EN
      r_vstart   <= '0;
`endif
      busy       <= 1'b0;
      illegal    <= 1'b0;
      beat_valid <= 1'b0;
      elem_idx   <= '0;
      lane_en    <= '0;
      reg_off    <= '0;
      byte_off   <= '0;
      beat_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      illegal <= 1'b0;
      done    <= 1'b0;
      if (flush) begin
        r_state    <= S_IDLE;
        busy       <= 1'b0;
        beat_valid <= 1'b0;
        beat_last  <= 1'b0;
        lane_en    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (sew > 3'd2) begin
                illegal <= 1'b1;
              end else begin
                r_vl  <= vl;
                r_sew <= sew;
`ifdef RV32V_VSTART_EN
                r_vstart <= vstart;
`endif
                busy  <= 1'b1;
                if (w_go_run) begin
                  r_state    <= S_RUN;
                  beat_valid <= 1'b1;
                  elem_idx   <= w_src_idx;
                  lane_en    <= w_lane_en;
                  reg_off    <= w_reg_off;
                  byte_off   <= w_byte_off;
                  beat_last  <= w_beat_last;
                end else begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
                end
              end
            end
          end
          S_RUN: begin
            if (beat_ready) begin
              if (beat_last) begin
                r_state    <= S_DONE;
                beat_valid <= 1'b0;
                beat_last  <= 1'b0;
                lane_en    <= '0;
                done       <= 1'b1;
              end else begin
                elem_idx   <= w_src_idx;
                lane_en    <= w_lane_en;
                reg_off    <= w_reg_off;
                byte_off   <= w_byte_off;
                beat_last  <= w_beat_last;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv32v_lane_sequencer.sv
// Scoreboard bench for rv32v_lane_sequencer: directed instructions push expected beats, a monitor pops on handshake.
module tb_rv32v_lane_sequencer;

  logic       CLK, nRST, start, flush, beat_ready;
  logic [7:0] vl, vstart;
  logic [2:0] sew;
  logic       busy, illegal, beat_valid, beat_last, done;
  logic [7:0] elem_idx;
  logic [1:0] lane_en;
  logic [2:0] reg_off;
  logic [3:0] byte_off;

  rv32v_lane_sequencer #(.VLEN(128), .NUM_LANES(2), .VL_W(8)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .vl(vl), .sew(sew), .vstart(vstart),
    .flush(flush), .busy(busy), .illegal(illegal), .beat_valid(beat_valid),
    .beat_ready(beat_ready), .elem_idx(elem_idx), .lane_en(lane_en), .reg_off(reg_off),
    .byte_off(byte_off), .beat_last(beat_last), .done(done)
  );

  typedef struct {int idx; int lane; int roff; int boff; int last;} beat_t;
  beat_t beat_q[$];
  int checks = 0, failures = 0;
  int got_done = 0, exp_done = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input int lane, input int roff, input int boff, input int last);
    beat_t b;
    b.idx = idx; b.lane = lane; b.roff = roff; b.boff = boff; b.last = last;
    beat_q.push_back(b);
  endtask

  // Monitor: compares each accepted beat against the oldest expected one.
  initial begin
    beat_t b;
    forever begin
      @(negedge CLK);
      if (done) got_done++;
      if (beat_valid && beat_ready) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", int'(elem_idx), -1);
        end else begin
          b = beat_q.pop_front();
          chk("elem_idx", int'(elem_idx), b.idx);
          chk("lane_en", int'(lane_en), b.lane);
          chk("reg_off", int'(reg_off), b.roff);
          chk("byte_off", int'(byte_off), b.boff);
          chk("beat_last", int'(beat_last), b.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input int l, input int s, input int vs);
    start = 1'b1; vl = 8'(l); sew = 3'(s); vstart = 8'(vs);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_busy_low"}, int'(busy), 0);
    chk({name, "_beats_left"}, beat_q.size(), 0);
    chk({name, "_done_count"}, got_done, exp_done);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0; start = 1'b0; flush = 1'b0; beat_ready = 1'b1;
    vl = '0; sew = '0; vstart = '0;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(beat_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_lane_en", int'(lane_en), 0);
    chk("rst_elem_idx", int'(elem_idx), 0);

    // vl=5 SEW32
    push(0, 3, 0, 0, 0); push(2, 3, 0, 8, 0); push(4, 1, 1, 0, 1);
    exp_done++;
    issue(5, 2, 0);
    chk("t1_latency_valid", int'(beat_valid), 1);
    chk("t1_busy", int'(busy), 1);
    wait_idle("t1");

    // vl=32 SEW8
    for (int k = 0; k < 16; k++) push(2*k, 3, (k >= 8) ? 1 : 0, (2*k) % 16, (k == 15) ? 1 : 0);
    exp_done++;
    issue(32, 0, 0);
    wait_idle("t2");

    // vl=6 SEW16 with a 3-cycle stall on the second beat
    push(0, 3, 0, 0, 0); push(2, 3, 0, 4, 0); push(4, 3, 0, 8, 1);
    exp_done++;
    issue(6, 1, 0);
    tick();
    beat_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3_stall_idx", int'(elem_idx), 2);
      chk("t3_stall_valid", int'(beat_valid), 1);
      chk("t3_stall_boff", int'(byte_off), 4);
    end
    beat_ready = 1'b1;
    wait_idle("t3");

    // vl=0, then illegal SEW64
    exp_done++;
    issue(0, 2, 0);
    chk("t4_no_valid", int'(beat_valid), 0);
    chk("t4_done_pulse", int'(done), 1);
    wait_idle("t4a");
    issue(4, 3, 0);
    chk("t4_illegal", int'(illegal), 1);
    chk("t4_illegal_busy", int'(busy), 0);
    tick();
    chk("t4_illegal_drop", int'(illegal), 0);
    chk("t4_illegal_novalid", int'(beat_valid), 0);
    chk("t4_illegal_nodone", got_done, exp_done);

    // flush during beat 2 of vl=8, then a fresh instruction
    push(0, 3, 0, 0, 0);
    issue(8, 2, 0);
    tick();
    chk("t5_pre_flush_idx", int'(elem_idx), 2);
    flush = 1'b1; beat_ready = 1'b0;
    tick();
    flush = 1'b0; beat_ready = 1'b1;
    chk("t5_flush_busy", int'(busy), 0);
    chk("t5_flush_valid", int'(beat_valid), 0);
    tick();
    chk("t5_flush_nodone", got_done, exp_done);
    push(0, 3, 0, 0, 1);
    exp_done++;
    issue(2, 0, 0);
    chk("t5_restart_valid", int'(beat_valid), 1);
    wait_idle("t5");

`ifdef RV32V_VSTART_EN
    push(2, 2, 0, 8, 0); push(4, 3, 1, 0, 0); push(6, 1, 1, 8, 1);
    exp_done++;
    issue(7, 2, 3);
    wait_idle("t6a");
    exp_done++;
    issue(7, 2, 7);
    chk("t6_no_valid", int'(beat_valid), 0);
    chk("t6_done_pulse", int'(done), 1);
    wait_idle("t6b");
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
